// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared constants and the clog2 helper for the interrupt queue.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int ID_NONE   = 0;
    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : irq_fifo
// Purpose  : DEPTH x ID_W ID buffer with occupancy count, async reset.
// Revision : 1.0 - initial release
// ============================================================================
module irq_fifo
    import irq_pkg::*;
#(
    parameter int ID_W  = 3,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ID_W-1:0]       din,
    input  logic                  pop,
    output logic [ID_W-1:0]       dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int c_aw = clog2(DEPTH);

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle makes room, so a push into a full buffer is safe.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_queue_ctrl
// Purpose  : Sticky interrupt collector, RR/fixed arbiter and ID queue.
// Revision : 1.0 - initial release
// ============================================================================
module irq_queue_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 7,
    parameter int ID_W  = 3,
    parameter int DEPTH = 16,
    parameter int MODE  = MODE_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      irq_in,
    input  logic [N_SRC-1:0]      irq_mask,
    input  logic                  eirq,
    output logic                  irq_valid,
    output logic [ID_W-1:0]       irq_id,
    output logic [N_SRC-1:0]      pending,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int c_sidx_w = (N_SRC > 1) ? clog2(N_SRC) : 1;
    localparam logic [c_sidx_w-1:0] c_ptr_rst = c_sidx_w'(N_SRC - 1);

    logic [N_SRC-1:0]    r_pend;
    logic [c_sidx_w-1:0] r_ptr;
    logic                r_valid;
    logic [ID_W-1:0]     r_id;
    logic                r_ovf;

    logic [N_SRC-1:0]    w_cand;
    logic [N_SRC-1:0]    w_grant;
    logic                w_found;
    logic [c_sidx_w-1:0] w_gidx;
    logic [c_sidx_w-1:0] w_idx;
    logic                w_full;
    logic                w_empty;
    logic [ID_W-1:0]     w_head;
    logic [ID_W-1:0]     w_push_id;
    logic                w_load;
    logic                w_pop;
    logic                w_ovf_set;

    assign w_cand = r_pend & ~irq_mask;

    // No grant while full: the pending bit simply waits for a free entry.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        if (!w_full) begin
            if (MODE == MODE_PRIO) begin
                for (int i = N_SRC - 1; i >= 0; i--) begin
                    if (w_cand[i]) begin
                        w_found = 1'b1;
                        w_gidx  = c_sidx_w'(i);
                    end
                end
            end else begin
                for (int off = 1; off <= N_SRC; off++) begin
                    w_idx = c_sidx_w'((int'(r_ptr) + off) % N_SRC);
                    if (!w_found && w_cand[w_idx]) begin
                        w_found = 1'b1;
                        w_gidx  = w_idx;
                    end
                end
            end
        end
    end

    assign w_grant   = w_found ? (N_SRC'(1) << w_gidx) : '0;
    assign w_push_id = ID_W'(w_gidx) + ID_W'(1);
    assign w_ovf_set = |(irq_in & r_pend & ~w_grant);
    assign w_load    = !r_valid || eirq;
    assign w_pop     = w_load && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_ptr  <= c_ptr_rst;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | irq_in;
            if (w_found) r_ptr <= w_gidx;
            if (w_ovf_set)         r_ovf <= 1'b1;
            else if (clr_overflow) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= ID_W'(ID_NONE);
        end else if (w_load) begin
            if (!w_empty) begin
                r_valid <= 1'b1;
                r_id    <= w_head;
            end else begin
                r_valid <= 1'b0;
                r_id    <= ID_W'(ID_NONE);
            end
        end
    end

    irq_fifo #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_found),
        .din   (w_push_id),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    assign irq_valid = r_valid;
    assign irq_id    = r_id;
    assign pending   = r_pend;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_irq_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_queue_ctrl
// Purpose  : Randomized check of RR and fixed-priority instances vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_queue_ctrl;

    localparam int N  = 7;
    localparam int IW = 3;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq_in = '0;
    logic [N-1:0]  irq_mask = '0;
    logic          eirq = 1'b0;
    logic          clr_overflow = 1'b0;

    logic          rr_valid, pr_valid;
    logic [IW-1:0] rr_id, pr_id;
    logic [N-1:0]  rr_pend, pr_pend;
    logic [CW-1:0] rr_cnt, pr_cnt;
    logic          rr_ovf, pr_ovf;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
    bit [N-1:0] m_pend  [2];
    bit         m_valid [2];
    int         m_id    [2];
    int         m_ptr   [2];
    bit         m_ovf   [2];
    int         m_buf   [2][D];
    int         m_head  [2];
    int         m_size  [2];

    always #5 clk = ~clk;

    irq_queue_ctrl #(.N_SRC(N), .ID_W(IW), .DEPTH(D), .MODE(0)) u_rr (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .eirq(eirq),
        .irq_valid(rr_valid), .irq_id(rr_id), .pending(rr_pend), .count(rr_cnt),
        .overflow(rr_ovf), .clr_overflow(clr_overflow)
    );

    irq_queue_ctrl #(.N_SRC(N), .ID_W(IW), .DEPTH(D), .MODE(1)) u_pr (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .eirq(eirq),
        .irq_valid(pr_valid), .irq_id(pr_id), .pending(pr_pend), .count(pr_cnt),
        .overflow(pr_ovf), .clr_overflow(clr_overflow)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_valid[m] = 1'b0; m_id[m] = 0; m_ptr[m] = N - 1;
            m_ovf[m] = 1'b0; m_head[m] = 0; m_size[m] = 0;
        end
    endtask

    // One clock of the behavioural model, evaluated with the inputs at the edge.
    task automatic model_step(input int m);
        int g;
        bit set;
        bit [N-1:0] cand;
        g = -1;
        set = 1'b0;
        cand = m_pend[m] & ~irq_mask;
        if (m_size[m] < D) begin
            if (m == 1) begin
                for (int i = 0; i < N; i++) if (g < 0 && cand[i]) g = i;
            end else begin
                for (int off = 1; off <= N; off++) begin
                    int idx;
                    idx = (m_ptr[m] + off) % N;
                    if (g < 0 && cand[idx]) g = idx;
                end
            end
        end
        for (int i = 0; i < N; i++) if (irq_in[i] && m_pend[m][i] && i != g) set = 1'b1;
        if (!m_valid[m] || eirq) begin
            if (m_size[m] > 0) begin
                m_valid[m] = 1'b1;
                m_id[m]    = m_buf[m][m_head[m]];
                m_head[m]  = (m_head[m] + 1) % D;
                m_size[m]  = m_size[m] - 1;
            end else begin
                m_valid[m] = 1'b0;
                m_id[m]    = 0;
            end
        end
        if (g >= 0) begin
            m_buf[m][(m_head[m] + m_size[m]) % D] = g + 1;
            m_size[m]    = m_size[m] + 1;
            m_pend[m][g] = 1'b0;
            m_ptr[m]     = g;
        end
        m_pend[m] = m_pend[m] | irq_in;
        if (set)               m_ovf[m] = 1'b1;
        else if (clr_overflow) m_ovf[m] = 1'b0;
    endtask

    task automatic compare_all();
        chk_eq("rr_valid", rr_valid, m_valid[0]);
        chk_eq("rr_id",    rr_id,    m_id[0]);
        chk_eq("rr_pend",  rr_pend,  m_pend[0]);
        chk_eq("rr_count", rr_cnt,   m_size[0]);
        chk_eq("rr_ovf",   rr_ovf,   m_ovf[0]);
        chk_eq("pr_valid", pr_valid, m_valid[1]);
        chk_eq("pr_id",    pr_id,    m_id[1]);
        chk_eq("pr_pend",  pr_pend,  m_pend[1]);
        chk_eq("pr_count", pr_cnt,   m_size[1]);
        chk_eq("pr_ovf",   pr_ovf,   m_ovf[1]);
    endtask

    task automatic apply(input logic [N-1:0] irq, input logic [N-1:0] msk,
                         input logic e, input logic clr);
        irq_in = irq; irq_mask = msk; eirq = e; clr_overflow = clr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_valid"}, {rr_valid, pr_valid}, 0);
        chk_eq({tag, "_id"},    {rr_id, pr_id}, 0);
        chk_eq({tag, "_pend"},  {rr_pend, pr_pend}, 0);
        chk_eq({tag, "_count"}, {rr_cnt, pr_cnt}, 0);
        chk_eq({tag, "_ovf"},   {rr_ovf, pr_ovf}, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Single pulse on source 2: ID 3 two edges later, gone after one eirq.
    task automatic directed_single();
        apply(7'b0000100, '0, 1'b0, 1'b0);
        chk_eq("lat_k0_valid", rr_valid, 0);
        apply('0, '0, 1'b0, 1'b0);
        chk_eq("lat_k1_valid", rr_valid, 0);
        apply('0, '0, 1'b0, 1'b0);
        chk_eq("lat_k2_valid", rr_valid, 1);
        chk_eq("lat_k2_id", rr_id, 3);
        apply('0, '0, 1'b1, 1'b0);
        chk_eq("eoi_valid", rr_valid, 0);
        chk_eq("eoi_count", rr_cnt, 0);
    endtask

    task automatic random_phase(input int cycles, input int p_irq, input int p_e);
        logic [N-1:0] irq;
        logic [N-1:0] msk;
        msk = '0;
        for (int c = 0; c < cycles; c++) begin
            if (c % 40 == 0) msk = N'($urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) irq[i] = ($urandom_range(0, 99) < p_irq);
            apply(irq, msk, ($urandom_range(0, 99) < p_e), ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        int p_irq_tab [4];
        int p_e_tab   [4];
        p_irq_tab = '{30, 10, 40, 5};
        p_e_tab   = '{70, 0, 95, 25};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        release_reset();
        directed_single();

        for (int ph = 0; ph < 8; ph++) begin
            random_phase(150, p_irq_tab[ph % 4], p_e_tab[ph % 4]);
        end

        // Fill the queue without accepting, then reset asynchronously mid-flight.
        random_phase(20, 30, 0);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        irq_in = '0; irq_mask = '0; eirq = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        directed_single();

        random_phase(300, 20, 60);

        for (int c = 0; c < 40; c++) apply('0, '0, 1'b1, 1'b1);
        chk_eq("drain_pend", {rr_pend, pr_pend}, 0);
        chk_eq("drain_valid", {rr_valid, pr_valid}, 0);
        chk_eq("drain_ovf", {rr_ovf, pr_ovf}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
